// File: rtl/ctrl_pipeline.sv
// Control-signal pipeline (ID/EX, EX/MEM, MEM/WB) with load-use stall and branch flush.
// Optional macro HAZARD_DETECT_EN enables the load-use stall; without it stall is tied to 0.
module ctrl_pipeline (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_RegDst,
  input  logic       id_Branch,
  input  logic       id_MemRead,
  input  logic       id_MemtoReg,
  input  logic       id_MemWrite,
  input  logic       id_ALUSrc,
  input  logic       id_RegWrite,
  input  logic [1:0] id_ALUOp,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       mem_zero,
  output logic       ex_RegDst,
  output logic       ex_ALUSrc,
  output logic       ex_MemRead,
  output logic [1:0] ex_ALUOp,
  output logic [4:0] ex_rt,
  output logic       mem_Branch,
  output logic       mem_MemRead,
  output logic       mem_MemWrite,
  output logic       wb_RegWrite,
  output logic       wb_MemtoReg,
  output logic       stall,
  output logic       flush
);

  typedef struct packed {
    logic       reg_dst;
    logic       branch;
    logic       mem_read;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic [1:0] alu_op;
    logic [4:0] rt;
  } idex_t;

  typedef struct packed {
    logic branch;
    logic mem_read;
    logic mem_write;
    logic reg_write;
    logic mem_to_reg;
  } exmem_t;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } memwb_t;

  idex_t  idex;
  exmem_t exmem;
  memwb_t memwb;
  idex_t  id_bundle;

  assign id_bundle = '{reg_dst: id_RegDst, branch: id_Branch, mem_read: id_MemRead,
                       mem_to_reg: id_MemtoReg, mem_write: id_MemWrite, alu_src: id_ALUSrc,
                       reg_write: id_RegWrite, alu_op: id_ALUOp, rt: id_rt};

`ifdef HAZARD_DETECT_EN
  // Load in EX whose destination feeds the instruction in ID; $zero never creates a hazard.
  assign stall = idex.mem_read && (idex.rt != 5'd0) &&
                 ((idex.rt == id_rs) || (idex.rt == id_rt));
`else
  logic unused_rs;
  assign unused_rs = ^id_rs;
  assign stall = 1'b0;
`endif

  assign flush = exmem.branch && mem_zero;

  // A flush squashes both younger stages and therefore overrides a simultaneous stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idex  <= '0;
      exmem <= '0;
      memwb <= '0;
    end else begin
      memwb <= '{reg_write: exmem.reg_write, mem_to_reg: exmem.mem_to_reg};
      if (flush) begin
        exmem <= '0;
      end else begin
        exmem <= '{branch: idex.branch, mem_read: idex.mem_read, mem_write: idex.mem_write,
                   reg_write: idex.reg_write, mem_to_reg: idex.mem_to_reg};
      end
      if (flush || stall) begin
        idex <= '0;
      end else begin
        idex <= id_bundle;
      end
    end
  end

  assign ex_RegDst    = idex.reg_dst;
  assign ex_ALUSrc    = idex.alu_src;
  assign ex_MemRead   = idex.mem_read;
  assign ex_ALUOp     = idex.alu_op;
  assign ex_rt        = idex.rt;
  assign mem_Branch   = exmem.branch;
  assign mem_MemRead  = exmem.mem_read;
  assign mem_MemWrite = exmem.mem_write;
  assign wb_RegWrite  = memwb.reg_write;
  assign wb_MemtoReg  = memwb.mem_to_reg;

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Bench for ctrl_pipeline: directed hazard/branch/reset scenarios plus random traffic
// checked against an in-flight instruction model.
module tb_ctrl_pipeline;

  typedef struct packed {
    logic       regdst;
    logic       branch;
    logic       memread;
    logic       memtoreg;
    logic       memwrite;
    logic       alusrc;
    logic       regwrite;
    logic [1:0] aluop;
    logic [4:0] rt;
  } ctl_t;

`ifdef HAZARD_DETECT_EN
  localparam bit hz_en = 1'b1;
`else
  localparam bit hz_en = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       id_RegDst, id_Branch, id_MemRead, id_MemtoReg, id_MemWrite, id_ALUSrc, id_RegWrite;
  logic [1:0] id_ALUOp;
  logic [4:0] id_rs, id_rt;
  logic       mem_zero;
  logic       ex_RegDst, ex_ALUSrc, ex_MemRead;
  logic [1:0] ex_ALUOp;
  logic [4:0] ex_rt;
  logic       mem_Branch, mem_MemRead, mem_MemWrite;
  logic       wb_RegWrite, wb_MemtoReg;
  logic       stall, flush;

  int total = 0;
  int bad   = 0;

  // Model: the instruction (or bubble) occupying each stage, oldest last.
  ctl_t pipe[3];
  logic last_stall;

  ctrl_pipeline dut (
    .clk(clk), .rst(rst),
    .id_RegDst(id_RegDst), .id_Branch(id_Branch), .id_MemRead(id_MemRead),
    .id_MemtoReg(id_MemtoReg), .id_MemWrite(id_MemWrite), .id_ALUSrc(id_ALUSrc),
    .id_RegWrite(id_RegWrite), .id_ALUOp(id_ALUOp), .id_rs(id_rs), .id_rt(id_rt),
    .mem_zero(mem_zero),
    .ex_RegDst(ex_RegDst), .ex_ALUSrc(ex_ALUSrc), .ex_MemRead(ex_MemRead),
    .ex_ALUOp(ex_ALUOp), .ex_rt(ex_rt),
    .mem_Branch(mem_Branch), .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite),
    .wb_RegWrite(wb_RegWrite), .wb_MemtoReg(wb_MemtoReg),
    .stall(stall), .flush(flush)
  );

  always #5 clk = ~clk;

  function automatic ctl_t mk(logic regdst, logic branch, logic memread, logic memtoreg,
                              logic memwrite, logic alusrc, logic regwrite,
                              logic [1:0] aluop, logic [4:0] rt);
    ctl_t c;
    c = '{regdst, branch, memread, memtoreg, memwrite, alusrc, regwrite, aluop, rt};
    return c;
  endfunction

  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(string tag);
    chk({tag, ".ex_RegDst"},    8'(ex_RegDst),    8'(pipe[0].regdst));
    chk({tag, ".ex_ALUSrc"},    8'(ex_ALUSrc),    8'(pipe[0].alusrc));
    chk({tag, ".ex_MemRead"},   8'(ex_MemRead),   8'(pipe[0].memread));
    chk({tag, ".ex_ALUOp"},     8'(ex_ALUOp),     8'(pipe[0].aluop));
    chk({tag, ".ex_rt"},        8'(ex_rt),        8'(pipe[0].rt));
    chk({tag, ".mem_Branch"},   8'(mem_Branch),   8'(pipe[1].branch));
    chk({tag, ".mem_MemRead"},  8'(mem_MemRead),  8'(pipe[1].memread));
    chk({tag, ".mem_MemWrite"}, 8'(mem_MemWrite), 8'(pipe[1].memwrite));
    chk({tag, ".wb_RegWrite"},  8'(wb_RegWrite),  8'(pipe[2].regwrite));
    chk({tag, ".wb_MemtoReg"},  8'(wb_MemtoReg),  8'(pipe[2].memtoreg));
  endtask

  // Called just after a falling edge: drive ID, check stall/flush, take one rising edge.
  task automatic step(string tag, ctl_t id, logic [4:0] rs, logic zero);
    logic s, f;
    id_RegDst = id.regdst; id_Branch = id.branch; id_MemRead = id.memread;
    id_MemtoReg = id.memtoreg; id_MemWrite = id.memwrite; id_ALUSrc = id.alusrc;
    id_RegWrite = id.regwrite; id_ALUOp = id.aluop; id_rt = id.rt; id_rs = rs;
    mem_zero = zero;
    f = pipe[1].branch && zero;
    s = hz_en && pipe[0].memread && (pipe[0].rt != 5'd0) &&
        ((pipe[0].rt == rs) || (pipe[0].rt == id.rt));
    #1;
    chk({tag, ".stall"}, 8'(stall), 8'(s));
    chk({tag, ".flush"}, 8'(flush), 8'(f));
    last_stall = s;
    @(posedge clk);
    pipe[2] = pipe[1];
    pipe[1] = f ? ctl_t'(0) : pipe[0];
    pipe[0] = (f || s) ? ctl_t'(0) : id;
    #1;
    check_outs(tag);
    @(negedge clk);
  endtask

  task automatic reset_pulse(string tag);
    #1 rst = 1'b1;
    #1;
    pipe[0] = '0; pipe[1] = '0; pipe[2] = '0;
    check_outs(tag);
    chk({tag, ".stall"}, 8'(stall), 8'd0);
    chk({tag, ".flush"}, 8'(flush), 8'd0);
    #1 rst = 1'b0;
  endtask

  initial begin
    ctl_t lw, lw0, rtype, beq, addi, nop, r;
    logic [4:0] rs_r;
    lw    = mk(0, 0, 1, 1, 0, 1, 1, 2'b00, 5'd5);
    lw0   = mk(0, 0, 1, 1, 0, 1, 1, 2'b00, 5'd0);
    rtype = mk(1, 0, 0, 0, 0, 0, 1, 2'b10, 5'd6);
    beq   = mk(0, 1, 0, 0, 0, 0, 0, 2'b01, 5'd7);
    addi  = mk(0, 0, 0, 0, 0, 1, 1, 2'b00, 5'd8);
    nop   = '0;
    pipe[0] = '0; pipe[1] = '0; pipe[2] = '0;
    last_stall = 1'b0;

    rst = 1'b1;
    id_RegDst = 0; id_Branch = 0; id_MemRead = 0; id_MemtoReg = 0; id_MemWrite = 0;
    id_ALUSrc = 0; id_RegWrite = 0; id_ALUOp = 0; id_rs = 0; id_rt = 0; mem_zero = 0;
    repeat (2) @(negedge clk);
    check_outs("reset");
    chk("reset.stall", 8'(stall), 8'd0);
    chk("reset.flush", 8'(flush), 8'd0);
    rst = 1'b0;

    // Load followed by dependent use.
    step("lw", lw, 5'd1, 1'b0);
    step("use", rtype, 5'd5, 1'b0);
    chk("lu_stall", 8'(stall), 8'd0);
    chk("use_ex_regdst", 8'(ex_RegDst), hz_en ? 8'd0 : 8'd1);
    if (last_stall) step("use_retry", rtype, 5'd5, 1'b0);
    else step("after_use", nop, 5'd0, 1'b0);
    chk("lw_wb_memtoreg", 8'(wb_MemtoReg), 8'd1);
    step("drain0", nop, 5'd0, 1'b0);

    // Load to $zero never stalls.
    step("lw0", lw0, 5'd1, 1'b0);
    step("use0", rtype, 5'd0, 1'b0);
    step("drain1", nop, 5'd0, 1'b0);

    // Branch not taken, then taken.
    step("beq_nt", beq, 5'd1, 1'b0);
    step("nt_1", addi, 5'd2, 1'b0);
    step("nt_2", rtype, 5'd2, 1'b0);
    step("beq_t", beq, 5'd1, 1'b0);
    step("t_1", addi, 5'd2, 1'b0);
    step("t_2", rtype, 5'd2, 1'b1);
    chk("t_ex_alusrc", 8'(ex_ALUSrc), 8'd0);
    chk("t_mem_regdst_path", 8'(mem_Branch), 8'd0);

    // Flush and load-use in the same cycle.
    step("beq_s", beq, 5'd1, 1'b0);
    step("lw_s", lw, 5'd1, 1'b0);
    step("use_s", rtype, 5'd5, 1'b1);
    chk("sim_ex_memread", 8'(ex_MemRead), 8'd0);
    chk("sim_mem_memread", 8'(mem_MemRead), 8'd0);
    step("post_s", rtype, 5'd5, 1'b0);

    // Reset mid-flight with addi in EX.
    step("addi", addi, 5'd3, 1'b0);
    reset_pulse("rst_addi");
    step("r_after_rst", rtype, 5'd3, 1'b0);
    chk("rst_ex_regdst", 8'(ex_RegDst), 8'd1);
    chk("rst_ex_aluop", 8'(ex_ALUOp), 8'd2);

    // Reset while a stall is pending.
    step("lw_r", lw, 5'd1, 1'b0);
    id_rs = 5'd5; id_rt = 5'd6;
    reset_pulse("rst_stall");
    step("r_after_rst2", rtype, 5'd5, 1'b0);

    // Random traffic; a stalled instruction is re-presented as IF/ID would hold it.
    r = nop; rs_r = 0;
    for (int i = 0; i < 300; i++) begin
      if (!last_stall) begin
        r = ctl_t'($urandom);
        r.rt = 5'($urandom_range(0, 3));
        rs_r = 5'($urandom_range(0, 3));
      end
      step("rand", r, rs_r, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ctrl_pipeline.md
CTRL_PIPELINE -- requirements
Module: ctrl_pipeline

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk input 1, rising-edge clock; rst input 1, asynchronous active-high reset.
REQ-002 id_RegDst, id_Branch, id_MemRead, id_MemtoReg, id_MemWrite, id_ALUSrc, id_RegWrite SHALL each be an input, 1 bit wide, carrying the decoded control bits of the instruction in ID.
REQ-003 id_ALUOp SHALL be an input, 2 bits wide, carrying the decoded ALU operation class.
REQ-004 id_rs and id_rt SHALL each be an input, 5 bits wide, giving the source register numbers of the instruction in ID.
REQ-005 mem_zero SHALL be an input, 1 bit wide, giving the ALU zero flag of the instruction in MEM.
REQ-006 ex_RegDst, ex_ALUSrc and ex_MemRead SHALL each be an output, 1 bit wide; ex_ALUOp SHALL be an output, 2 bits wide; all are EX-stage controls.
REQ-007 ex_rt SHALL be an output, 5 bits wide, giving the rt number of the instruction in EX.
REQ-008 mem_Branch, mem_MemRead and mem_MemWrite SHALL each be an output, 1 bit wide; all are MEM-stage controls.
REQ-009 wb_RegWrite and wb_MemtoReg SHALL each be an output, 1 bit wide; both are WB-stage controls.
REQ-010 stall SHALL be an output, 1 bit wide, and SHALL hold PC and IF/ID for one cycle when high.
REQ-011 flush SHALL be an output, 1 bit wide, and SHALL signal a taken branch, squashing the younger instructions.

Function
REQ-012 Three register stages (ID/EX, EX/MEM, MEM/WB) SHALL advance on every rising clk edge; no enable input exists.
REQ-013 Latency: an id_* value sampled at edge N SHALL appear on ex_* after N, on mem_* after N+1, and on wb_* after N+2.
REQ-014 ID/EX SHALL capture all id_* controls plus id_rt; EX/MEM SHALL forward Branch, MemRead, MemWrite, RegWrite and MemtoReg; MEM/WB SHALL forward RegWrite and MemtoReg.
REQ-015 stall SHALL be combinational: stall = ex_MemRead AND ex_rt != 0 AND (ex_rt == id_rs OR ex_rt == id_rt).
REQ-016 flush SHALL be combinational: flush = mem_Branch AND mem_zero.
REQ-017 On an edge with stall=1 and flush=0, ID/EX SHALL load a bubble (all controls 0, rt 0), while EX/MEM and MEM/WB advance normally.
REQ-018 On an edge with flush=1, ID/EX and EX/MEM SHALL load bubbles and MEM/WB SHALL advance normally; flush SHALL have priority over stall.
REQ-019 A stall SHALL last exactly one cycle per load-use hazard, because the inserted bubble clears ex_MemRead.
REQ-020 A bubble SHALL never assert a write or memory control (RegWrite, MemWrite, MemRead, Branch all 0).
REQ-021 Back-to-back loads with chained dependencies SHALL each produce their own single-cycle stall.

Reset
REQ-022 While rst is high, all stage registers SHALL be 0 immediately, without waiting for clk; every ex_*, mem_* and wb_* output SHALL be 0, and stall and flush SHALL be 0.
REQ-023 A rst assertion in the middle of a stall or flush SHALL discard all in-flight controls, and the first edge after rst deasserts SHALL capture id_* normally.

Configuration
REQ-024 Macro HAZARD_DETECT_EN SHALL be the single configuration option; when it is defined, stall SHALL behave per REQ-015 and REQ-017.
REQ-025 When HAZARD_DETECT_EN is undefined, stall SHALL be tied to 0 and no ID/EX bubble SHALL be inserted for a load-use hazard; flush SHALL behave the same in both builds.

Verification
REQ-026 Load then dependent use: lw (MemRead=1, MemtoReg=1, RegWrite=1, ALUSrc=1, rt=5), then R-type with rs=5 -> stall=1 for exactly one cycle, next ex_* all 0, and wb_MemtoReg=1 three edges after the lw.
REQ-027 Hazard on $zero: lw with rt=0 followed by a use with rs=0 -> stall stays 0.
REQ-028 Taken branch: beq (Branch=1, ALUOp=01) with mem_zero=1 in MEM -> flush=1, and after the edge ex_* and mem_* are 0; with mem_zero=0 -> flush=0 and no squash.
REQ-029 Simultaneous events: flush=1 and a load-use hazard in the same cycle -> bubbles per REQ-018, with stall not extending the squash.
REQ-030 Reset mid-flight: addi (ALUSrc=1, RegWrite=1) in EX, then rst pulsed between edges -> all outputs 0 immediately; after release, the next R-type gives ex_RegDst=1 and ex_ALUOp=10 one edge later.
REQ-031 The bench SHALL rerun the REQ-026 scenario with HAZARD_DETECT_EN undefined -> stall stays 0 and the R-type controls reach EX on the very next edge.
